turn_sequencer: RTL
===================

# turn_sequencer

Per-turn controller for the 2048 game datapath. It accepts a direction key and drives the 4-bit `mode` bus that sequences the move unit, the tile spawner and the registered judge multiplexer. It time-shares that multiplexer between the move-validity vector (`mode=0011`) and the merge-possible vector (`mode=0100`), then decides whether to spawn a tile, declare game over, or return to idle. It sits between the keyboard/button debouncer and the board datapath.

## Interface
- `TIMEOUT`, default 255: maximum cycles to wait for `move_done` or `spawn_done` before aborting the turn.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  direction key pending.
- `key_dir`  in  2  direction: 00 up, 01 down, 10 left, 11 right.
- `key_ready`  out  1  key accepted on a cycle with `key_valid & key_ready`.
- `new_game`  in  1  restart request.
- `mode`  out  4  mode code to the datapath and the judge mux.
- `dir`  out  2  latched direction of the current turn.
- `move_start`  out  1  one-cycle pulse starting the move unit.
- `move_done`  in  1  move unit finished.
- `judge`  in  16  registered output of the judge mux.
- `spawn_req`  out  1  one-cycle pulse requesting a new tile.
- `spawn_done`  in  1  spawner finished.
- `no_move`  out  1  one-cycle pulse: key produced no board change.
- `game_over`  out  1  level; set in OVER.
- `err`  out  1  sticky timeout flag.
- `move_count`  out  16  completed valid turns, saturating.

## Operation
- States and `mode` values: IDLE 0000; MOVE, WAIT_MOVE 0001; J1_SET, J1_CAP 0011; SPAWN, WAIT_SPAWN 0010; J2_SET, J2_CAP 0100; OVER 1111. `mode` is registered, a pure function of the state.
- IDLE: `key_ready=1`. `new_game` clears `move_count`, `err` and `game_over`, and stays in IDLE. If `new_game` and `key_valid` arrive together, `new_game` wins and the key is dropped. An accepted key latches `dir` and goes to MOVE.
- MOVE: `move_start=1` for this one cycle, then WAIT_MOVE.
- WAIT_MOVE: `move_done` goes to J1_SET. `move_done` is sampled only in this state.
- J1_SET, then J1_CAP: on the J1_CAP exit edge `judge` is captured.
  - Nonzero (board changed): go to SPAWN.
  - Zero: pulse `no_move` and go to IDLE. `move_count` is unchanged.
- SPAWN: `spawn_req=1` for one cycle, then WAIT_SPAWN. WAIT_SPAWN goes to J2_SET on `spawn_done`.
- J2_SET, then J2_CAP: on exit `move_count` increments, saturating at FFFF.
  - `judge==0` (no merge or empty cell possible): go to OVER.
  - Otherwise: go to IDLE.
- OVER: `game_over=1` and `key_ready=0`. Keys are ignored. `new_game` goes to IDLE with the same clears as in IDLE. `new_game` is ignored in all other states.
- Timeout: a counter clears on entry to WAIT_MOVE or WAIT_SPAWN and increments each cycle in those states. On reaching `TIMEOUT` without done, set `err` and go to IDLE. `move_count` is unchanged.
  - A done arriving in the same cycle the count reaches `TIMEOUT` is honoured, with no error.
- Reset, any state: state IDLE, `mode=0000`, `dir=00`, `move_count=0`, `err=0`. All pulses and `game_over` are 0. The in-flight turn is abandoned.

## Timing
- Key accepted at edge e: MOVE and `move_start` during cycle e..e+1; `mode=0001` from e.
- Judge mux latency is one cycle. `mode=0011` is visible from edge t (entering J1_SET). The mux registers `judge1` at t+1, and this block samples `judge` at t+2. J2 uses the same two-cycle pattern.
- Minimum turn, with dones returned the cycle after request: key to IDLE in 8 cycles.
- `no_move` and the `move_count` update both occur on the edge leaving the capture state.

## Structure
- Shared package `judge_pkg`:
  - mode constants MODE_IDLE=4'b0000, MODE_MOVE=4'b0001, MODE_SPAWN=4'b0010, MODE_JUDGE1=4'b0011, MODE_JUDGE2=4'b0100, MODE_OVER=4'b1111;
  - direction constants;
  - state enum.
- The judge mux consumes the same mode constants.
- One sub-module, `handshake_timer`: clear/enable counter with a `TIMEOUT` compare, reused for both wait states.

## Test plan
- Normal turn: key_dir=10 with move_done, judge=0x0001 at J1, spawn_done, judge=0x0100 at J2 -> `spawn_req` one pulse, `move_count` 0->1, back to IDLE, `game_over=0`.
- Invalid move: judge=0x0000 at J1 -> `no_move` one pulse, no `spawn_req`, `move_count` unchanged, IDLE.
- Game over: judge=0x0000 at J2 -> `mode=1111`, `game_over=1`, key ignored. `new_game` -> IDLE, `move_count=0`.
- Timeout: TIMEOUT=4, `move_done` never asserted -> `err=1` after 4 wait cycles, IDLE. `err` stays set until `new_game`.
- Mode sequence check: per turn, `mode` goes 0001, 0011 for exactly 2 cycles, 0010, 0100 for exactly 2 cycles, then 0000. Judge sampling is exactly 2 cycles after entering J1_SET/J2_SET.
- Reset mid-turn in WAIT_SPAWN -> next cycle `mode=0000`, `move_count=0`, `spawn_done` afterwards ignored.

Source files
------------

// File: rtl/judge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : judge_pkg
// Brief    : Mode codes, direction codes and turn-sequencer state encoding
//            shared by the turn sequencer and the registered judge mux.
// Revision : 1.0 - initial release
// ============================================================================
package judge_pkg;

  // Mode bus codes driven to the datapath and the judge mux
  localparam logic [3:0] MODE_IDLE   = 4'b0000;
  localparam logic [3:0] MODE_MOVE   = 4'b0001;
  localparam logic [3:0] MODE_SPAWN  = 4'b0010;
  localparam logic [3:0] MODE_JUDGE1 = 4'b0011;
  localparam logic [3:0] MODE_JUDGE2 = 4'b0100;
  localparam logic [3:0] MODE_OVER   = 4'b1111;

  // Direction key codes
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_MOVE       = 4'd1,
    S_WAIT_MOVE  = 4'd2,
    S_J1_SET     = 4'd3,
    S_J1_CAP     = 4'd4,
    S_SPAWN      = 4'd5,
    S_WAIT_SPAWN = 4'd6,
    S_J2_SET     = 4'd7,
    S_J2_CAP     = 4'd8,
    S_OVER       = 4'd9
  } state_t;

  // Mode code is a pure function of the state
  function automatic logic [3:0] mode_of(input state_t s);
    case (s)
      S_MOVE, S_WAIT_MOVE:   mode_of = MODE_MOVE;
      S_J1_SET, S_J1_CAP:    mode_of = MODE_JUDGE1;
      S_SPAWN, S_WAIT_SPAWN: mode_of = MODE_SPAWN;
      S_J2_SET, S_J2_CAP:    mode_of = MODE_JUDGE2;
      S_OVER:                mode_of = MODE_OVER;
      default:               mode_of = MODE_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/handshake_timer.sv
`default_nettype none
// ============================================================================
// Module   : handshake_timer
// Brief    : Clear/enable cycle counter flagging when a wait has lasted
//            TIMEOUT cycles. Shared by both handshake wait states.
// Revision : 1.0 - initial release
// ============================================================================
module handshake_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  // Count wait cycles; parks at TIMEOUT so it can never wrap
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != CW'(TIMEOUT))) begin
      r_count <= r_count + 1'b1;
    end
  end

  // High during the wait cycle whose closing edge brings the count to TIMEOUT
  assign o_expired = (r_count == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : turn_sequencer
// Brief    : Per-turn controller for the 2048 datapath: move, judge board
//            change, spawn, judge merge-possible, then idle or game over.
// Revision : 1.0 - initial release
// ============================================================================
module turn_sequencer
  import judge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [1:0]  key_dir,
  output logic        key_ready,
  input  logic        new_game,
  output logic [3:0]  mode,
  output logic [1:0]  dir,
  output logic        move_start,
  input  logic        move_done,
  input  logic [15:0] judge,
  output logic        spawn_req,
  input  logic        spawn_done,
  output logic        no_move,
  output logic        game_over,
  output logic        err,
  output logic [15:0] move_count
);

  state_t r_state;
  state_t w_state_nxt;

  logic        w_key_ready;
  logic        w_accept;
  logic        w_clear;
  logic        w_timer_en;
  logic        w_timeout;
  logic        w_no_move;
  logic        w_count_inc;
  logic        w_expired;

  logic [3:0]  r_mode;
  logic [1:0]  r_dir;
  logic        r_move_start;
  logic        r_spawn_req;
  logic        r_no_move;
  logic        r_game_over;
  logic        r_err;
  logic [15:0] r_move_count;

  // Counter is held clear outside the wait states, so it starts at 0 on entry
  handshake_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (~w_timer_en),
    .i_en      (w_timer_en),
    .o_expired (w_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    w_state_nxt = r_state;
    w_key_ready = 1'b0;
    w_accept    = 1'b0;
    w_clear     = 1'b0;
    w_timer_en  = 1'b0;
    w_timeout   = 1'b0;
    w_no_move   = 1'b0;
    w_count_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        // new_game has priority; a coincident key is dropped, not accepted
        w_key_ready = ~new_game;
        if (new_game) begin
          w_clear = 1'b1;
        end else if (key_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_MOVE;
        end
      end
      S_MOVE:   w_state_nxt = S_WAIT_MOVE;
      S_WAIT_MOVE: begin
        w_timer_en = 1'b1;
        // A done on the expiry cycle still wins
        if (move_done) begin
          w_state_nxt = S_J1_SET;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_J1_SET: w_state_nxt = S_J1_CAP;
      S_J1_CAP: begin
        if (|judge) begin
          w_state_nxt = S_SPAWN;
        end else begin
          w_no_move   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_SPAWN:  w_state_nxt = S_WAIT_SPAWN;
      S_WAIT_SPAWN: begin
        w_timer_en = 1'b1;
        if (spawn_done) begin
          w_state_nxt = S_J2_SET;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_J2_SET: w_state_nxt = S_J2_CAP;
      S_J2_CAP: begin
        w_count_inc = 1'b1;
        w_state_nxt = (judge == 16'h0000) ? S_OVER : S_IDLE;
      end
      S_OVER: begin
        if (new_game) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs, timed to the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode       <= MODE_IDLE;
      r_dir        <= DIR_UP;
      r_move_start <= 1'b0;
      r_spawn_req  <= 1'b0;
      r_no_move    <= 1'b0;
      r_game_over  <= 1'b0;
      r_err        <= 1'b0;
      r_move_count <= 16'h0000;
    end else begin
      r_mode       <= mode_of(w_state_nxt);
      r_move_start <= (w_state_nxt == S_MOVE);
      r_spawn_req  <= (w_state_nxt == S_SPAWN);
      r_no_move    <= w_no_move;
      r_game_over  <= (w_state_nxt == S_OVER);
      if (w_accept) begin
        r_dir <= key_dir;
      end
      if (w_clear) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_clear) begin
        r_move_count <= 16'h0000;
      end else if (w_count_inc && (r_move_count != 16'hFFFF)) begin
        r_move_count <= r_move_count + 16'h0001;
      end
    end
  end

  assign key_ready  = w_key_ready;
  assign mode       = r_mode;
  assign dir        = r_dir;
  assign move_start = r_move_start;
  assign spawn_req  = r_spawn_req;
  assign no_move    = r_no_move;
  assign game_over  = r_game_over;
  assign err        = r_err;
  assign move_count = r_move_count;

endmodule
`default_nettype wire
